multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle MIPS main control FSM; replaces single-cycle opcode decode. Sequences IF/ID/EX/MEM/WB
//  over a shared memory and ALU, stalls on a mem_ready handshake, aborts on a memory watchdog timeout.
//  Drives the multi-cycle datapath; alu_op feeds the existing ALU controller together with func.
// PARAMETERS
//  OPCODE_W   6   opcode field width
//  TIMEOUT    16  max consecutive mem_ready-low cycles in a memory state; 0 disables the watchdog
//  TIMEOUT_W  8   watchdog counter width; TIMEOUT must be < 2**TIMEOUT_W
// PORTS
//  clk           in   1         clock; all state updates on posedge
//  rst           in   1         synchronous, active-high reset
//  opcode        in   OPCODE_W  IR[31:26]; stable from ID until return to IF
//  zero          in   1         ALU zero flag
//  mem_ready     in   1         memory access completes this cycle
//  i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_write  out 1
//  reg_dst, alu_src_b, alu_op, pc_src, data_to_write  out 2
//  illegal_op    out  1         one-cycle pulse: unknown opcode in ID
//  mem_timeout   out  1         one-cycle pulse: watchdog expired
//  instr_done    out  1         one-cycle pulse: last cycle of an instruction
// BEHAVIOUR
//  - Reset: state<=IF, watchdog<=0 on the clk edge with rst=1. While rst=1 all outputs are forced to 0.
//    rst mid-instruction abandons it: no reg_write/mem_write/pc_write after the reset edge.
//  - Outputs are Moore decode of state (default 0), except ir_write/pc_write in IF,
//    and pc_write in BR, which also depend on mem_ready and zero.
//  - IF: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_src=00. If mem_ready: ir_write=1, pc_write=1
//    -> ID. Else hold.
//  - ID: alu_src_b=11, alu_op=00 (branch target).
//    Next state: 000000->EX_R; 100011/101011->MA; 000100/000101->BR; 001001/001010->EX_I;
//    000010/000011/000110->JMP. Any other opcode: illegal_op=1 -> IF.
//  - EX_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
//  - WB_R: reg_write=1, reg_dst=01, instr_done=1 -> IF.
//  - MA: alu_src_a=1, alu_src_b=10, alu_op=00 -> MR (lw) or MW (sw).
//  - MR: i_or_d=1, mem_read=1; mem_ready -> WB_L, else hold.
//  - WB_L: reg_write=1, mem_to_reg=1, reg_dst=00, instr_done=1 -> IF.
//  - MW: i_or_d=1, mem_write=1; mem_ready -> IF with instr_done=1, else hold.
//  - EX_I: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) or 11 (slti) -> WB_I.
//  - WB_I: reg_write=1, reg_dst=00, data_to_write=10 if slti else 00; instr_done=1 -> IF.
//  - BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01;
//    pc_write = zero (beq) or ~zero (bne, 000101); instr_done=1 -> IF.
//  - JMP: pc_write=1; pc_src=10 (j, jal) or 11 (jr). jal also: reg_write=1, reg_dst=10,
//    data_to_write=01. instr_done=1 -> IF.
//  - Watchdog: counts cycles in IF/MR/MW with mem_ready=0. Clears on any state change or mem_ready=1.
//    When count reaches TIMEOUT-1 with mem_ready still 0: mem_timeout=1, next state IF,
//    no ir_write/pc_write/mem_write that cycle's edge, count<=0.
//    mem_ready=1 on that same cycle wins: normal completion, no timeout.
//  - Latency with mem_ready=1 throughout: R/addi/slti 4 cycles, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
// TESTING
//  1 lw, mem_ready low 3 cycles in IF and 2 in MR -> 10 cycles to instr_done; reg_write=1,
//    mem_to_reg=1 only in WB_L.
//  2 beq, zero=1 -> pc_write=1, pc_src=01 in BR. Repeat with zero=0 -> pc_write=0.
//    bne with zero=0 -> pc_write=1.
//  3 jal -> JMP cycle: pc_write=1, pc_src=10, reg_dst=10, data_to_write=01, reg_write=1.
//    jr -> pc_src=11, reg_write=0.
//  4 opcode 111111 -> illegal_op=1 for one cycle in ID, next cycle IF; no reg_write/mem_write asserted.
//  5 TIMEOUT=4, sw with mem_ready held 0 in MW -> mem_timeout pulses on 4th MW cycle, mem_write drops,
//    state IF; mem_ready=1 on that 4th cycle instead -> instr_done, no timeout.
//  6 rst=1 for one cycle during MW -> all outputs 0 that cycle; FSM in IF next cycle with mem_read=1,
//    mem_write=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM: sequences IF/ID/EX/MEM/WB over a shared memory and ALU,
// stalls on mem_ready and aborts a memory access when the watchdog expires.
module multicycle_controller #(
  parameter int unsigned OPCODE_W  = 6,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic                pc_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [1:0]          data_to_write,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic                instr_done
);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_MA, S_MR, S_WB_L, S_MW, S_EX_I, S_WB_I, S_BR, S_JMP
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'b000110);

  localparam bit                   WD_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 mem_state_c;
  logic                 timeout_c;

  // Watchdog fires on the last allowed stalled cycle; a same-cycle mem_ready wins.
  assign mem_state_c = (state_q == S_IF) || (state_q == S_MR) || (state_q == S_MW);
  assign timeout_c   = WD_EN && mem_state_c && !mem_ready && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    pc_write      = 1'b0;
    reg_dst       = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    data_to_write = 2'b00;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'b11;
        if (opcode == OP_R)                          state_d = S_EX_R;
        else if (opcode == OP_LW || opcode == OP_SW)     state_d = S_MA;
        else if (opcode == OP_BEQ || opcode == OP_BNE)   state_d = S_BR;
        else if (opcode == OP_ADDI || opcode == OP_SLTI) state_d = S_EX_I;
        else if (opcode == OP_J || opcode == OP_JAL || opcode == OP_JR) state_d = S_JMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_IF;
        end
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)      state_d = S_WB_L;
        else if (timeout_c) state_d = S_IF;
      end
      S_WB_L: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_MW: begin
        i_or_d     = 1'b1;
        mem_write  = !timeout_c;
        instr_done = mem_ready;
        if (mem_ready || timeout_c) state_d = S_IF;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write     = 1'b1;
        data_to_write = (opcode == OP_SLTI) ? 2'b10 : 2'b00;
        instr_done    = 1'b1;
        state_d       = S_IF;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_src     = (opcode == OP_JR) ? 2'b11 : 2'b10;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write     = 1'b1;
          reg_dst       = 2'b10;
          data_to_write = 2'b01;
        end
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if (timeout_c) begin
      mem_timeout = 1'b1;
      state_d     = S_IF;
    end

    // Count only consecutive stalled cycles within one memory state.
    wd_d = '0;
    if (mem_state_c && !mem_ready && !timeout_c && (state_d == state_q))
      wd_d = wd_q + TIMEOUT_W'(1);

    // Reset overrides every control output so nothing commits on the reset edge.
    if (rst) begin
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      pc_write      = 1'b0;
      reg_dst       = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
      data_to_write = 2'b00;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle control-word checks against an
// instruction-level model, directed scenarios followed by randomized instruction streams.
module tb_multicycle_controller;

  localparam int TO = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001001, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_JR = 6'b000110;

  typedef struct packed {
    logic       i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_write;
    logic [1:0] reg_dst, alu_src_b, alu_op, pc_src, data_to_write;
    logic       illegal_op, mem_timeout, instr_done;
  } outs_t;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] opcode;
  logic i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_write;
  logic [1:0] reg_dst, alu_src_b, alu_op, pc_src, data_to_write;
  logic illegal_op, mem_timeout, instr_done;
  outs_t obs;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.OPCODE_W(6), .TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_write(pc_write),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .data_to_write(data_to_write), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_done(instr_done)
  );

  assign obs = {i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_write,
                reg_dst, alu_src_b, alu_op, pc_src, data_to_write, illegal_op, mem_timeout, instr_done};

  // One clock cycle: sample mid-cycle against the expected control word, then advance.
  task automatic check(input outs_t e, input string tag);
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input int got, input int want, input string tag);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic noise();
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
  endtask

  // kind 0 = fetch, 1 = load read, 2 = store write; wait_n stalled cycles precede mem_ready.
  task automatic mem_phase(input int kind, input int wait_n, output bit done);
    int    c   = 0;
    int    rem = wait_n;
    outs_t e;
    done = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      e           = '0;
      e.mem_read  = (kind != 2);
      e.mem_write = (kind == 2);
      e.i_or_d    = (kind != 0);
      if (kind == 0) e.alu_src_b = 2'b01;
      mem_ready = (rem == 0);
      zero      = 1'($urandom);
      if (rem == 0) begin
        if (kind == 0) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
        if (kind == 2) e.instr_done = 1'b1;
        check(e, (kind == 0) ? "fetch_done" : (kind == 1) ? "mr_done" : "mw_done");
        done = 1'b1;
        return;
      end
      if (c == TO - 1) begin
        e.mem_timeout = 1'b1;
        if (kind == 2) e.mem_write = 1'b0;
        check(e, (kind == 0) ? "fetch_timeout" : (kind == 1) ? "mr_timeout" : "mw_timeout");
        c = 0;
        rem--;
        if (kind != 0) return;
      end else begin
        check(e, (kind == 0) ? "fetch_wait" : (kind == 1) ? "mr_wait" : "mw_wait");
        c++;
        rem--;
      end
    end
  endtask

  // Whole-instruction reference: the cycle sequence each instruction class produces.
  task automatic run_instr(input logic [5:0] op, input int w_if, input int w_mem,
                           input logic z, output int lat);
    outs_t e;
    bit    ok;
    int    t0 = ncyc;
    opcode = op;
    mem_phase(0, w_if, ok);
    e = '0; e.alu_src_b = 2'b11;
    noise();
    if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J, OP_JAL, OP_JR})) begin
      e.illegal_op = 1'b1;
      check(e, "id_illegal");
      lat = ncyc - t0;
      return;
    end
    check(e, "id");
    case (op)
      OP_R: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10; noise(); check(e, "ex_r");
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01; e.instr_done = 1'b1; noise(); check(e, "wb_r");
      end
      OP_LW, OP_SW: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; noise(); check(e, "ma");
        mem_phase((op == OP_LW) ? 1 : 2, w_mem, ok);
        if (ok && op == OP_LW) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; noise();
          check(e, "wb_l");
        end
      end
      OP_ADDI, OP_SLTI: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_op = (op == OP_SLTI) ? 2'b11 : 2'b00; noise(); check(e, "ex_i");
        e = '0; e.reg_write = 1'b1; e.data_to_write = (op == OP_SLTI) ? 2'b10 : 2'b00;
        e.instr_done = 1'b1; noise(); check(e, "wb_i");
      end
      OP_BEQ, OP_BNE: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.instr_done = 1'b1;
        e.pc_write = (op == OP_BNE) ? ~z : z;
        noise(); zero = z; check(e, "br");
      end
      default: begin
        e = '0; e.pc_write = 1'b1; e.instr_done = 1'b1;
        e.pc_src = (op == OP_JR) ? 2'b11 : 2'b10;
        if (op == OP_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.data_to_write = 2'b01; end
        noise(); check(e, "jmp");
      end
    endcase
    lat = ncyc - t0;
  endtask

  logic [5:0] ops [12] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                           OP_J, OP_JAL, OP_JR, 6'b111111, 6'b001000};

  initial begin
    int    lat;
    bit    ok;
    outs_t e;

    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    check('0, "reset0");
    check('0, "reset1");
    rst = 1'b0;

    run_instr(OP_LW, 3, 2, 1'b0, lat);   check_int(lat, 10, "lat_lw_stalled");
    run_instr(OP_BEQ, 0, 0, 1'b1, lat);  check_int(lat, 3, "lat_beq");
    run_instr(OP_BEQ, 0, 0, 1'b0, lat);
    run_instr(OP_BNE, 0, 0, 1'b0, lat);
    run_instr(OP_BNE, 1, 0, 1'b1, lat);
    run_instr(OP_JAL, 0, 0, 1'b0, lat);  check_int(lat, 3, "lat_jal");
    run_instr(OP_JR, 0, 0, 1'b0, lat);
    run_instr(OP_J, 0, 0, 1'b0, lat);
    run_instr(6'b111111, 0, 0, 1'b0, lat); check_int(lat, 2, "lat_illegal");
    run_instr(OP_R, 0, 0, 1'b0, lat);    check_int(lat, 4, "lat_r");
    run_instr(OP_ADDI, 0, 0, 1'b0, lat); check_int(lat, 4, "lat_addi");
    run_instr(OP_SLTI, 0, 0, 1'b0, lat); check_int(lat, 4, "lat_slti");
    run_instr(OP_LW, 0, 0, 1'b0, lat);   check_int(lat, 5, "lat_lw");
    run_instr(OP_SW, 0, 0, 1'b0, lat);   check_int(lat, 4, "lat_sw");
    run_instr(OP_SW, 0, 9, 1'b0, lat);   check_int(lat, 7, "lat_sw_timeout");
    run_instr(OP_SW, 0, 3, 1'b0, lat);   check_int(lat, 7, "lat_sw_ready_at_limit");
    run_instr(OP_LW, 0, 8, 1'b0, lat);   check_int(lat, 7, "lat_lw_timeout");
    run_instr(OP_R, 5, 0, 1'b0, lat);    check_int(lat, 9, "lat_fetch_timeout");

    // Reset landing in the middle of a store stall.
    opcode = OP_SW;
    mem_phase(0, 0, ok);
    e = '0; e.alu_src_b = 2'b11; noise(); check(e, "id_sw");
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; noise(); check(e, "ma_sw");
    e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1; mem_ready = 1'b0; check(e, "mw_before_rst");
    rst = 1'b1; mem_ready = 1'b1; check('0, "rst_in_mw");
    rst = 1'b0;
    run_instr(OP_R, 0, 0, 1'b0, lat);    check_int(lat, 4, "lat_after_rst");

    for (int i = 0; i < 150; i++) begin
      run_instr(ops[$urandom_range(0, 11)], $urandom_range(0, 6), $urandom_range(0, 6),
                1'($urandom), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
